// File: rtl/bp_cfg_loader.sv
// Post-reset configuration sequencer: freezes every core, writes its id and CCE mode,
// then unfreezes all cores over a valid/ready cfg bus.
module bp_cfg_loader #(
  parameter int num_core_p       = 1,
  parameter int cfg_addr_width_p = 16,
  parameter int cfg_data_width_p = 32,
  parameter int core_id_width_p  = (num_core_p > 1) ? $clog2(num_core_p) : 1
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        start_i,
  input  logic                        cce_mode_i,
  output logic                        cfg_v_o,
  input  logic                        cfg_ready_i,
  output logic [core_id_width_p-1:0]  cfg_core_o,
  output logic [cfg_addr_width_p-1:0] cfg_addr_o,
  output logic [cfg_data_width_p-1:0] cfg_data_o,
  output logic                        busy_o,
  output logic                        done_o
);

  typedef enum logic [1:0] {
    e_idle     = 2'd0,
    e_config   = 2'd1,
    e_unfreeze = 2'd2,
    e_done     = 2'd3
  } state_e;

  localparam logic [cfg_addr_width_p-1:0] freeze_addr_lp  = cfg_addr_width_p'(16'h0000);
  localparam logic [cfg_addr_width_p-1:0] core_id_addr_lp = cfg_addr_width_p'(16'h0004);
  localparam logic [cfg_addr_width_p-1:0] cce_mode_addr_lp = cfg_addr_width_p'(16'h0008);
  localparam logic [core_id_width_p-1:0]  last_core_lp    = core_id_width_p'(num_core_p - 1);
  localparam logic [core_id_width_p-1:0]  core_one_lp     = core_id_width_p'(1);

  state_e                     r_state, w_state_next;
  logic [core_id_width_p-1:0] r_core_cnt, w_core_cnt_next;
  logic [1:0]                 r_step_cnt, w_step_cnt_next;
  logic                       r_mode, w_mode_next;

  // State and counter registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state    <= e_idle;
      r_core_cnt <= '0;
      r_step_cnt <= 2'd0;
      r_mode     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_core_cnt <= w_core_cnt_next;
      r_step_cnt <= w_step_cnt_next;
      r_mode     <= w_mode_next;
    end
  end

  // Next-state and output decode; outputs are forced idle while reset_i is high so an
  // in-flight write is withdrawn in the reset cycle itself
  always_comb begin
    w_state_next    = r_state;
    w_core_cnt_next = r_core_cnt;
    w_step_cnt_next = r_step_cnt;
    w_mode_next     = r_mode;
    cfg_v_o         = 1'b0;
    cfg_core_o      = '0;
    cfg_addr_o      = '0;
    cfg_data_o      = '0;
    busy_o          = 1'b0;
    done_o          = 1'b0;
    if (reset_i) begin
      w_state_next = e_idle;
    end else begin
      case (r_state)
        e_idle: begin
          if (start_i) begin
            w_mode_next     = cce_mode_i;
            w_core_cnt_next = '0;
            w_step_cnt_next = 2'd0;
            w_state_next    = e_config;
          end else begin
            w_state_next = e_idle;
          end
        end
        e_config: begin
          cfg_v_o    = 1'b1;
          busy_o     = 1'b1;
          cfg_core_o = r_core_cnt;
          case (r_step_cnt)
            2'd0: begin
              cfg_addr_o = freeze_addr_lp;
              cfg_data_o = cfg_data_width_p'(1'b1);
            end
            2'd1: begin
              cfg_addr_o = core_id_addr_lp;
              cfg_data_o = cfg_data_width_p'(r_core_cnt);
            end
            2'd2: begin
              cfg_addr_o = cce_mode_addr_lp;
              cfg_data_o = cfg_data_width_p'(r_mode);
            end
            default: begin
              cfg_addr_o = freeze_addr_lp;
              cfg_data_o = cfg_data_width_p'(1'b1);
            end
          endcase
          if (cfg_ready_i) begin
            if (r_step_cnt >= 2'd2) begin
              w_step_cnt_next = 2'd0;
              if (r_core_cnt == last_core_lp) begin
                w_core_cnt_next = '0;
                w_state_next    = e_unfreeze;
              end else begin
                w_core_cnt_next = r_core_cnt + core_one_lp;
              end
            end else begin
              w_step_cnt_next = r_step_cnt + 2'd1;
            end
          end else begin
            w_step_cnt_next = r_step_cnt;
          end
        end
        e_unfreeze: begin
          cfg_v_o    = 1'b1;
          busy_o     = 1'b1;
          cfg_core_o = r_core_cnt;
          cfg_addr_o = freeze_addr_lp;
          cfg_data_o = '0;
          if (cfg_ready_i) begin
            if (r_core_cnt == last_core_lp) begin
              w_core_cnt_next = '0;
              w_state_next    = e_done;
            end else begin
              w_core_cnt_next = r_core_cnt + core_one_lp;
            end
          end else begin
            w_core_cnt_next = r_core_cnt;
          end
        end
        e_done: begin
          done_o       = 1'b1;
          w_state_next = e_done;
        end
        default: begin
          w_state_next = e_idle;
        end
      endcase
    end
  end

endmodule
